// File: rtl/lc3b_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_responder
// Brief    : LC-3b memory-side responder. Latches a word read or byte-enabled
//            write, waits a programmable latency, then pulses mem_resp.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_LAT_LOAD = 4'(LATENCY - 1);
    localparam int         c_DEPTH    = 1 << ADDR_BITS;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_count;
    logic                   r_is_write;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [15:0]            r_wdata;
    logic [1:0]             r_be;
    logic [15:0]            r_rdata;
    logic [15:0]            r_mem [0:c_DEPTH-1];

    logic                   w_req;
    logic                   w_commit;

    assign w_req    = mem_read | mem_write;
    assign w_commit = (r_state == ST_WAIT) && (r_count == 4'd0);

    // Byte-address bit0 and bits above the word index are deliberately dropped.
    generate
        if (ADDR_BITS < 15) begin : g_addr_upper
            logic w_unused_addr;
            assign w_unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};
        end else begin : g_addr_full
            logic w_unused_addr;
            assign w_unused_addr = mem_address[0];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = ST_WAIT;
            ST_WAIT: if (r_count == 4'd0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch, latency counter and read-data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= 4'd0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 16'h0000;
            r_be       <= 2'b00;
            r_rdata    <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_is_write <= mem_write;
                        r_idx      <= mem_address[ADDR_BITS:1];
                        r_wdata    <= mem_wdata;
                        r_be       <= mem_byte_enable;
                        r_count    <= c_LAT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else if (!r_is_write) begin
                        r_rdata <= r_mem[r_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is not reset; an aborted access never reaches the commit cycle.
    always_ff @(posedge clk) begin
        if (w_commit && r_is_write) begin
            if (r_be[0]) r_mem[r_idx][7:0]  <= r_wdata[7:0];
            if (r_be[1]) r_mem[r_idx][15:8] <= r_wdata[15:8];
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_resp  = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b datapath/control memory interface.
- Accepts word reads and byte-enabled writes from the CPU, holds them for a programmable latency, then returns a one-cycle mem_resp with read data.
- Backed by an internal word array. Used as the simulation and FPGA memory behind the CPU and as a latency stress target for the control FSM's wait states.

Parameters:
- ADDR_BITS, 10, word-index width; the array holds 2**ADDR_BITS 16-bit words.
- LATENCY, 3, cycles from request acceptance to mem_resp rising; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset; one clock; polarity and synchronicity are fixed.
- mem_read  in  1  read request level, held by the CPU until mem_resp.
- mem_write  in  1  write request level, held by the CPU until mem_resp.
- mem_byte_enable  in  2  write lane enables: bit0 = data[7:0], bit1 = data[15:8].
- mem_address  in  16  byte address; bit0 ignored; word index = mem_address[ADDR_BITS:1].
- mem_wdata  in  16  write data.
- mem_rdata  out  16  read data; valid only while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is accepted and not yet completed (WAIT or RESP).

Behaviour:
- Reset (async, immediate):
  - state=IDLE, mem_resp=0, busy=0, mem_rdata=16'h0000, counter=0, latched request cleared.
  - Array contents are not cleared; they are undefined at power-up.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - At a clock edge with mem_read|mem_write=1, latch op, word index, wdata and byte enables.
  - Load counter=LATENCY-1 and go to WAIT.
  - Later changes on the inputs do not affect the pending access.
- WAIT:
  - Each edge with counter!=0 decrements the counter.
  - At the edge with counter==0, commit the access and go to RESP.
  - Read commit: mem_rdata <= array[idx].
  - Write commit: update only the enabled lanes of array[idx]; mem_rdata holds its previous value.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - The next edge returns to IDLE with mem_resp=0. A request in RESP is not sampled.
  - The earliest next acceptance is at the edge after RESP→IDLE. A request the CPU holds after its response is therefore treated as a new access.
- Timing:
  - Request first visible in cycle 0 → accepted at the end of cycle 0.
  - mem_resp is high during cycle LATENCY+1.
  - Back-to-back throughput is one access per LATENCY+2 cycles.
- Both mem_read and mem_write high at acceptance: write is performed; the access is treated as a write.
- mem_byte_enable=2'b00 on a write: no array change; mem_resp is still generated with normal latency.
- Reads ignore mem_byte_enable and always return the full word. The CPU selects the byte via address bit0.
- Address bits above ADDR_BITS are ignored, so addresses wrap modulo 2**(ADDR_BITS+1) bytes.
- Reset asserted in WAIT aborts the access: no array write occurs and no mem_resp is issued.
- Reset asserted in RESP drops mem_resp immediately. A write committed at the WAIT→RESP edge persists.
- busy=1 in WAIT and RESP, 0 in IDLE. Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. LATENCY=3; write 16'hBEEF to x0100 with be=11, then read x0100 → mem_resp high in cycle 4 of each request, exactly one cycle wide; read returns 16'hBEEF.
2. Write 16'h1234 to x0200 (be=11), write 16'hAB00 with be=10, write 16'h00CD with be=01, write 16'hFFFF with be=00, then read x0200 → returns 16'hABCD.
3. ADDR_BITS=10: write 16'h5A5A to x0010, read x0810 (wraps to the same word) → 16'h5A5A; read x0011 (bit0 ignored) → 16'h5A5A.
4. mem_read and mem_write both high with wdata 16'h7777 to x0300, then plain read x0300 → 16'h7777. Holding mem_read through RESP+1 yields a second mem_resp after another LATENCY+2 cycles.
5. Write 16'h1111 to x0400, then start a write of 16'h2222 to x0400 and assert reset 1 cycle after acceptance → mem_resp never pulses, busy drops to 0 immediately, subsequent read of x0400 → 16'h1111.
6. LATENCY=1 back-to-back reads of x0000 and x0002 with mem_read held → responses in cycles 2 and 5, and mem_address changes after acceptance do not alter the returned data.
